// File: rtl/pipelined_control_unit_if.sv
// pipelined_control_unit_if: ID-side inputs and the registered ID/EX control bundle.
interface pipelined_control_unit_if #(parameter int ALU_CTRL_W = 5);
    logic [31:0] id_instr;
    logic id_valid, flush_i, stall_o;
    logic ex_valid, ex_reg_write;
    logic [2:0] ex_imm_sel;
    logic [1:0] ex_rd_sel;
    logic ex_operand_a, ex_operand_b, ex_mem_en, ex_load, ex_store, ex_branch, ex_jal, ex_jalr;
    logic [ALU_CTRL_W-1:0] ex_alu_control;
    logic [2:0] ex_fun3;
    logic [4:0] ex_rd;
    logic ex_illegal;
    modport master(
        output id_instr, id_valid, flush_i,
        input stall_o, ex_valid, ex_reg_write, ex_imm_sel, ex_rd_sel, ex_operand_a, ex_operand_b,
        ex_mem_en, ex_load, ex_store, ex_branch, ex_jal, ex_jalr, ex_alu_control, ex_fun3, ex_rd, ex_illegal
    );
    modport slave(
        input id_instr, id_valid, flush_i,
        output stall_o, ex_valid, ex_reg_write, ex_imm_sel, ex_rd_sel, ex_operand_a, ex_operand_b,
        ex_mem_en, ex_load, ex_store, ex_branch, ex_jal, ex_jalr, ex_alu_control, ex_fun3, ex_rd, ex_illegal
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: RV32I(+M) decode registered into ID/EX with load-use, flush and MDU stall control.
module pipelined_control_unit #(
    parameter int ALU_CTRL_W = 5,
    parameter bit SUPPORT_M = 1'b1,
    parameter int MDU_LATENCY = 4
) (
    input logic clk,
    input logic rst_n,
    pipelined_control_unit_if.slave bus
);
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
        OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
        OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
    typedef enum logic {RUN, MDU_BUSY} state_t;
    typedef struct packed {
        logic valid, reg_write;
        logic [2:0] imm_sel;
        logic [1:0] rd_sel;
        logic op_a, op_b, mem_en, load, store, branch, jal, jalr;
        logic [ALU_CTRL_W-1:0] alu;
        logic [2:0] fun3;
        logic [4:0] rd;
        logic illegal;
    } ctrl_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    ctrl_t ex_q, ex_d, dec;
    logic mop, illegal, uses_rs2, load_use, busy;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    assign {f7, rs2, rs1, f3, rd, op} = bus.id_instr;
    function automatic logic [3:0] alu_code(input logic [2:0] f, input logic alt);
        return f == 3'd0 ? {3'b000, alt} : f == 3'd1 ? 4'd2 : f == 3'd2 ? 4'd3 : f == 3'd3 ? 4'd4 :
               f == 3'd4 ? 4'd5 : f == 3'd5 ? (alt ? 4'd7 : 4'd6) : f == 3'd6 ? 4'd8 : 4'd9;
    endfunction
    always_comb begin
        dec = '0;
        mop = 1'b0;
        illegal = 1'b0;
        dec.valid = 1'b1;
        dec.fun3 = f3;
        case (op)
            OP_R: begin
                dec.reg_write = 1'b1;
                mop = SUPPORT_M && f7 == 7'b0000001;
                illegal = !SUPPORT_M && f7 == 7'b0000001;
                dec.alu = mop ? ALU_CTRL_W'({2'b10, f3}) : ALU_CTRL_W'(alu_code(f3, f7[5]));
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.op_b = 1'b1;
                dec.alu = ALU_CTRL_W'(alu_code(f3, f3 == 3'd5 && f7[5]));
            end
            OP_LD: begin
                {dec.reg_write, dec.mem_en, dec.load, dec.op_b} = 4'b1111;
                dec.rd_sel = 2'd1;
            end
            OP_ST: begin
                {dec.mem_en, dec.store, dec.op_b} = 3'b111;
                dec.imm_sel = 3'd1;
            end
            OP_BR: begin
                dec.branch = 1'b1;
                dec.imm_sel = 3'd2;
                dec.alu = ALU_CTRL_W'(1);
            end
            OP_JAL: begin
                {dec.reg_write, dec.jal} = 2'b11;
                dec.rd_sel = 2'd2;
                dec.imm_sel = 3'd4;
            end
            OP_JALR: begin
                {dec.reg_write, dec.jalr, dec.op_b} = 3'b111;
                dec.rd_sel = 2'd2;
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.rd_sel = 2'd3;
                dec.imm_sel = 3'd3;
            end
            OP_AUIPC: begin
                {dec.reg_write, dec.op_a, dec.op_b} = 3'b111;
                dec.imm_sel = 3'd3;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec = '0;
            dec.valid = 1'b1;
            dec.illegal = 1'b1;
        end
        dec.rd = dec.reg_write ? rd : 5'd0;
    end
    // rs1 is always compared; rs2 only for formats that actually read it
    assign uses_rs2 = op == OP_R || op == OP_ST || op == OP_BR;
    assign load_use = ex_q.valid && ex_q.load && bus.id_valid && ex_q.rd != 5'd0 &&
                      (ex_q.rd == rs1 || (uses_rs2 && ex_q.rd == rs2));
    assign busy = state_q == MDU_BUSY;
    assign bus.stall_o = !bus.flush_i && (busy || load_use);
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        ex_d = ex_q;
        if (bus.flush_i) begin
            ex_d = '0;
            state_d = RUN;
            cnt_d = 4'd0;
        end else if (busy) begin
            cnt_d = cnt_q - 4'd1;
            state_d = cnt_q == 4'd1 ? RUN : MDU_BUSY;
        end else if (load_use) begin
            ex_d = '0;
        end else begin
            ex_d = bus.id_valid ? dec : '0;
            if (bus.id_valid && mop && MDU_LATENCY > 1) begin
                state_d = MDU_BUSY;
                cnt_d = 4'(MDU_LATENCY - 1);
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q <= 4'd0;
            ex_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            ex_q <= ex_d;
        end
    end
    assign {bus.ex_valid, bus.ex_reg_write, bus.ex_imm_sel, bus.ex_rd_sel, bus.ex_operand_a,
            bus.ex_operand_b, bus.ex_mem_en, bus.ex_load, bus.ex_store, bus.ex_branch, bus.ex_jal,
            bus.ex_jalr, bus.ex_alu_control, bus.ex_fun3, bus.ex_rd, bus.ex_illegal} = ex_q;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: randomized scoreboard bench plus directed flush, reset and no-M cases.
module tb_pipelined_control_unit;
    localparam int LAT = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    pipelined_control_unit_if #(.ALU_CTRL_W(5)) bif();
    pipelined_control_unit_if #(.ALU_CTRL_W(5)) nif();
    pipelined_control_unit #(.ALU_CTRL_W(5), .SUPPORT_M(1'b1), .MDU_LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bif));
    pipelined_control_unit #(.ALU_CTRL_W(5), .SUPPORT_M(1'b0), .MDU_LATENCY(LAT)) u_nom (
        .clk(clk), .rst_n(rst_n), .bus(nif));
    typedef struct packed {
        logic valid, rw;
        logic [2:0] imm;
        logic [1:0] rds;
        logic opa, opb, mem, ld, st, br, jal, jalr;
        logic [4:0] alu;
        logic [2:0] f3;
        logic [4:0] rd;
        logic ill;
    } ex_t;
    ex_t dut_ex, nom_ex, last_exp = '0;
    assign dut_ex = {bif.ex_valid, bif.ex_reg_write, bif.ex_imm_sel, bif.ex_rd_sel, bif.ex_operand_a,
                     bif.ex_operand_b, bif.ex_mem_en, bif.ex_load, bif.ex_store, bif.ex_branch,
                     bif.ex_jal, bif.ex_jalr, bif.ex_alu_control, bif.ex_fun3, bif.ex_rd, bif.ex_illegal};
    assign nom_ex = {nif.ex_valid, nif.ex_reg_write, nif.ex_imm_sel, nif.ex_rd_sel, nif.ex_operand_a,
                     nif.ex_operand_b, nif.ex_mem_en, nif.ex_load, nif.ex_store, nif.ex_branch,
                     nif.ex_jal, nif.ex_jalr, nif.ex_alu_control, nif.ex_fun3, nif.ex_rd, nif.ex_illegal};
    int checks = 0, errors = 0;
    bit mon_en = 1'b0, prev_stall = 1'b0;
    bit stall_q[$];
    ex_t ex_q[$];
    bit ex_mop = 1'b0;
    logic [4:0] ex_ld_rd = 5'd0;
    localparam logic [31:0] ADD3 = 32'h002081B3, LW5 = 32'h0000A283, ADD6 = 32'h00228333,
        MUL7 = 32'h022083B3, ADDI8 = 32'h00138413, LW0 = 32'h0000A003, ADD4X0 = 32'h00000233,
        BEQ = 32'h00208463, BAD = 32'h0000007F;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic ex_t model(input logic [31:0] ins, input bit sm);
        ex_t e = '0;
        int base[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        logic [2:0] f = ins[14:12];
        bit bad = 1'b0;
        e.valid = 1'b1;
        e.f3 = f;
        case (ins[6:0])
            7'h33: if (ins[31:25] == 7'h01) begin
                       if (sm) begin e.rw = 1'b1; e.alu = 5'(16 + int'(f)); end
                       else bad = 1'b1;
                   end else begin
                       e.rw = 1'b1;
                       e.alu = 5'(base[f] + int'((f == 3'd0 || f == 3'd5) && ins[30]));
                   end
            7'h13: begin e.rw = 1'b1; e.opb = 1'b1; e.alu = 5'(base[f] + int'(f == 3'd5 && ins[30])); end
            7'h03: begin e.rw = 1'b1; e.mem = 1'b1; e.ld = 1'b1; e.rds = 2'd1; e.opb = 1'b1; end
            7'h23: begin e.mem = 1'b1; e.st = 1'b1; e.imm = 3'd1; e.opb = 1'b1; end
            7'h63: begin e.br = 1'b1; e.imm = 3'd2; e.alu = 5'd1; end
            7'h6F: begin e.rw = 1'b1; e.jal = 1'b1; e.rds = 2'd2; e.imm = 3'd4; end
            7'h67: begin e.rw = 1'b1; e.jalr = 1'b1; e.rds = 2'd2; e.opb = 1'b1; end
            7'h37: begin e.rw = 1'b1; e.rds = 2'd3; e.imm = 3'd3; end
            7'h17: begin e.rw = 1'b1; e.opa = 1'b1; e.opb = 1'b1; e.imm = 3'd3; end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            e = '0;
            e.valid = 1'b1;
            e.ill = 1'b1;
        end
        e.rd = e.rw ? ins[11:7] : 5'd0;
        return e;
    endfunction
    function automatic logic [31:0] gen();
        logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        logic [6:0] f7s[4] = '{7'h00, 7'h20, 7'h01, 7'($urandom)};
        logic [6:0] op = ops[$urandom_range(9)];
        if (op == 7'h7F) op = 7'($urandom);
        return {f7s[$urandom_range(3)], 5'($urandom_range(3)), 5'($urandom_range(3)), 3'($urandom),
                5'($urandom_range(3)), op};
    endfunction
    // ID slot is held for as many cycles as the instruction in EX dictates
    task automatic issue(input bit v, input logic [31:0] ins);
        ex_t e = model(ins, 1'b1);
        int h = 0;
        bit rs2u = ins[6:0] inside {7'h33, 7'h23, 7'h63};
        if (ex_mop) h = LAT - 1;
        else if (v && ex_ld_rd != 5'd0 && (ex_ld_rd == ins[19:15] || (rs2u && ex_ld_rd == ins[24:20]))) h = 1;
        bif.id_valid = v;
        bif.id_instr = ins;
        repeat (h) stall_q.push_back(1'b1);
        stall_q.push_back(1'b0);
        if (v) ex_q.push_back(e);
        repeat (h + 1) tick();
        ex_mop = v && !e.ill && e.alu >= 5'd16;
        ex_ld_rd = (v && e.ld) ? e.rd : 5'd0;
    endtask
    always @(negedge clk) if (mon_en) begin
        if (stall_q.size() != 0) chk("stall", 32'(bif.stall_o), 32'(stall_q.pop_front()));
        if (!dut_ex.valid) chk("bubble", 32'(dut_ex), 32'd0);
        else if (prev_stall) chk("hold", 32'(dut_ex), 32'(last_exp));
        else if (ex_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra: unexpected ex entry 0x%0h", dut_ex);
        end else begin
            last_exp = ex_q.pop_front();
            chk("decode", 32'(dut_ex), 32'(last_exp));
        end
        prev_stall = bif.stall_o;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end
    initial begin
        logic [31:0] seq[7] = '{ADD3, LW5, ADD6, MUL7, ADDI8, LW0, ADD4X0};
        bif.id_valid = 1'b0; bif.id_instr = '0; bif.flush_i = 1'b0;
        nif.id_valid = 1'b0; nif.id_instr = '0; nif.flush_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ex", 32'(dut_ex), 32'd0);
        chk("rst_stall", 32'(bif.stall_o), 32'd0);
        chk("rst_nom_ex", 32'(nom_ex), 32'd0);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;
        foreach (seq[i]) issue(1'b1, seq[i]);
        repeat (300) issue($urandom_range(7) != 0, gen());
        bif.id_valid = 1'b0;
        for (int i = 0; i < 20 && ex_q.size() != 0; i++) tick();
        chk("drain", ex_q.size(), 0);
        tick();
        mon_en = 1'b0;
        stall_q.delete();
        repeat (LAT + 1) tick();
        bif.id_valid = 1'b1; bif.id_instr = BEQ;
        tick();
        chk("beq_in_ex", 32'(dut_ex), 32'(model(BEQ, 1'b1)));
        bif.id_instr = ADD3; bif.flush_i = 1'b1;
        #1 chk("flush_stall", 32'(bif.stall_o), 32'd0);
        tick();
        bif.flush_i = 1'b0;
        chk("flush_bubble", 32'(dut_ex), 32'd0);
        bif.id_instr = LW5;
        tick();
        bif.id_instr = ADD6;
        #1 chk("lu_stall", 32'(bif.stall_o), 32'd1);
        bif.flush_i = 1'b1;
        #1 chk("lu_flush_stall", 32'(bif.stall_o), 32'd0);
        tick();
        bif.flush_i = 1'b0;
        chk("lu_flush_bubble", 32'(dut_ex), 32'd0);
        bif.id_instr = MUL7;
        tick();
        bif.id_instr = ADDI8;
        #1 chk("mdu_stall", 32'(bif.stall_o), 32'd1);
        tick();
        chk("mdu_stall2", 32'(bif.stall_o), 32'd1);
        chk("mdu_hold", 32'(dut_ex), 32'(model(MUL7, 1'b1)));
        bif.flush_i = 1'b1;
        #1 chk("mdu_flush_stall", 32'(bif.stall_o), 32'd0);
        tick();
        bif.flush_i = 1'b0;
        #1 chk("mdu_flush_run", 32'(bif.stall_o), 32'd0);
        chk("mdu_flush_bubble", 32'(dut_ex), 32'd0);
        tick();
        chk("after_flush_issue", 32'(dut_ex), 32'(model(ADDI8, 1'b1)));
        bif.id_instr = MUL7;
        tick();
        bif.id_instr = ADD3;
        tick();
        #1 rst_n = 1'b0;
        #1 chk("async_rst_ex", 32'(dut_ex), 32'd0);
        chk("async_rst_stall", 32'(bif.stall_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_issue", 32'(dut_ex), 32'(model(ADD3, 1'b1)));
        chk("post_rst_stall", 32'(bif.stall_o), 32'd0);
        bif.id_valid = 1'b0;
        nif.id_valid = 1'b1; nif.id_instr = BAD;
        tick();
        chk("nom_bad_opcode", 32'(nom_ex), 32'(model(BAD, 1'b0)));
        chk("nom_bad_ill", 32'(nif.ex_illegal), 32'd1);
        nif.id_instr = MUL7;
        tick();
        chk("nom_mul", 32'(nom_ex), 32'(model(MUL7, 1'b0)));
        chk("nom_mul_flags", 32'({nif.ex_illegal, nif.ex_reg_write, nif.ex_mem_en}), 32'b100);
        chk("nom_mul_nostall", 32'(nif.stall_o), 32'd0);
        nif.id_valid = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
